uart_tx_mmio: RTL and testbench
===============================

UART_TX_MMIO -- requirements
Module: uart_tx_mmio

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 48000000: frequency of clk in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200: serial bit rate.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: TX byte FIFO entries, power of two, 2..16.
REQ-004 SHALL have port clk, input, 1: the one clock; all state on rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port io_sel, input, 1: high when the processor address is in IO space (decoded by SOC).
REQ-007 SHALL have port mem_addr, input, 32: byte address; only bits [3:2] used as register select.
REQ-008 SHALL have port mem_wdata, input, 32: store data from processor.
REQ-009 SHALL have port mem_wmask, input, 4: byte write strobes; any bit set = write.
REQ-010 SHALL have port mem_rstrb, input, 1: read strobe.
REQ-011 SHALL have port io_rdata, output, 32: registered read data.
REQ-012 SHALL have port TXD, output, 1: UART serial output, idle high.

Function
REQ-013 SHALL map registers: mem_addr[3:2]=0 TX_DATA (write-only), =1 STATUS (read-only); others read 0, writes ignored.
REQ-014 SHALL accept a write when io_sel=1, |mem_wmask=1, select=TX_DATA; pushes mem_wdata[7:0] into FIFO that cycle.
REQ-015 SHALL drop a push when FIFO full (including same cycle as a pop) and set sticky STATUS.overflow.
REQ-016 SHALL return on a read (io_sel & mem_rstrb) data in io_rdata one cycle later; io_rdata holds value otherwise.
REQ-017 SHALL format STATUS as: bit0 full, bit1 empty, bit2 overflow, bit3 tx_active, bits[31:4]=0.
REQ-018 SHALL clear overflow in the cycle after a STATUS read is sampled; an overflow in that same cycle keeps it set.
REQ-019 SHALL compute divisor DIV = CLK_FREQ_HZ / BAUD_RATE (integer truncation); each bit lasts exactly DIV clk cycles.
REQ-020 SHALL implement FSM IDLE -> START -> DATA -> STOP -> IDLE.
REQ-021 SHALL in IDLE drive TXD=1; when FIFO non-empty, pop head into shift register and enter START next cycle.
REQ-022 SHALL drive TXD=0 for DIV cycles in START, then 8 data bits LSB first in DATA (DIV cycles each), then TXD=1 for DIV cycles in STOP.
REQ-023 SHALL from STOP go to IDLE; back-to-back bytes have exactly one idle cycle between stop bit and next start bit.
REQ-024 SHALL keep tx_active=1 in START, DATA, STOP; 0 in IDLE.
REQ-025 SHALL register TXD (no combinational path from inputs to TXD).
REQ-026 SHALL make FIFO pointers wrap modulo FIFO_DEPTH with a separate count of 0..FIFO_DEPTH for full/empty.
REQ-027 SHALL accept a push into an empty FIFO while IDLE; pop occurs the following cycle (push-to-start-bit latency 2 cycles).

Reset
REQ-028 SHALL on reset assertion immediately set: FSM=IDLE, TXD=1, FIFO empty, overflow=0, io_rdata=0, bit/baud counters=0.
REQ-029 SHALL abort any frame in progress on reset; no partial frame resumes after release.
REQ-030 SHALL accept no write in a cycle where reset is asserted.

Verification (CLK_FREQ_HZ=1000000, BAUD_RATE=100000, DIV=10, FIFO_DEPTH=4)
REQ-031 SHALL cover: write 0x55 to TX_DATA -> TXD low 10 cycles starting 2 cycles later, then 1,0,1,0,1,0,1,0 each 10 cycles, stop high 10 cycles; frame 100 cycles.
REQ-032 SHALL cover: write 0x41,0x42 back-to-back -> two frames, one idle-high cycle between them, bytes decoded correctly by bench receiver.
REQ-033 SHALL cover: 6 writes in 6 consecutive cycles while idle -> first byte popped, next 4 stored, 6th dropped; STATUS reads 0x0D (full, overflow, active); 5 frames transmitted.
REQ-034 SHALL cover: read STATUS after overflow -> returns bit2=1; next STATUS read returns bit2=0.
REQ-035 SHALL cover: assert reset mid-DATA of byte 0xF0 with 2 bytes queued -> TXD=1 same cycle, STATUS reads 0x02 after release, no further frames.
REQ-036 SHALL cover: write with io_sel=0 or to mem_addr[3:2]=2 -> no FIFO push, TXD stays high, STATUS=0x02.

Source files
------------

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: TX_DATA/STATUS registers,
// a small byte FIFO and an 8N1 serializer with registered TXD.
module uart_tx_mmio #(
  parameter int CLK_FREQ_HZ = 48000000,
  parameter int BAUD_RATE   = 115200,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_sel,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wmask,
  input  logic        mem_rstrb,
  output logic [31:0] io_rdata,
  output logic        TXD
);

  localparam int DIV = CLK_FREQ_HZ / BAUD_RATE;
  localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);

  localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
  localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   rdata_q, rdata_d;

  logic [1:0]  regsel;
  logic        wr_req, rd_req, stat_rd;
  logic        full, empty, push, drop, pop;
  logic        active;
  logic [31:0] status;
  logic        unused_bits;

  assign regsel  = mem_addr[3:2];
  assign wr_req  = io_sel & (|mem_wmask) & (regsel == 2'd0);
  assign rd_req  = io_sel & mem_rstrb;
  assign stat_rd = rd_req & (regsel == 2'd1);

  assign full   = (cnt_q == CNT_FULL);
  assign empty  = (cnt_q == '0);
  assign push   = wr_req & ~full;
  assign drop   = wr_req & full;
  assign active = (state_q != S_IDLE);
  assign status = {28'd0, active, ovf_q, empty, full};

  assign unused_bits = ^{mem_addr[31:4], mem_addr[1:0], mem_wdata[31:8]};

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // A drop in the same cycle as the clearing read wins.
  always_comb begin
    ovf_d   = (ovf_q & ~stat_rd) | drop;
    rdata_d = rdata_q;
    if (rd_req) begin
      unique case (regsel)
        2'd1:    rdata_d = status;
        default: rdata_d = '0;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = 1'b1;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        txd_d = 1'b0;
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        txd_d = shift_q[0];
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        txd_d = 1'b1;
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          state_d = S_IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push && !reset) mem_q[wr_ptr_q] <= mem_wdata[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      rdata_q  <= rdata_d;
    end
  end

  assign io_rdata = rdata_q;
  assign TXD      = txd_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio at DIV=10, FIFO_DEPTH=4,
// with a background serial receiver collecting whole frames.
module tb_uart_tx_mmio;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        io_sel = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wmask = '0;
  logic        mem_rstrb = 1'b0;
  logic [31:0] io_rdata;
  logic        TXD;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int frame_err = 0;

  logic [7:0] rx_q [$];
  int         rx_t [$];

  uart_tx_mmio #(
    .CLK_FREQ_HZ(1000000),
    .BAUD_RATE  (100000),
    .FIFO_DEPTH (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .io_sel   (io_sel),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask),
    .mem_rstrb(mem_rstrb),
    .io_rdata (io_rdata),
    .TXD      (TXD)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic sel, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] m);
    @(negedge clk);
    io_sel    = sel;
    mem_addr  = a;
    mem_wdata = d;
    mem_wmask = m;
    mem_rstrb = 1'b0;
  endtask

  task automatic bus_idle();
    @(negedge clk);
    io_sel    = 1'b0;
    mem_wmask = '0;
    mem_rstrb = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    io_sel    = 1'b1;
    mem_addr  = a;
    mem_wmask = '0;
    mem_rstrb = 1'b1;
    @(negedge clk);
    io_sel    = 1'b0;
    mem_rstrb = 1'b0;
    d = io_rdata;
  endtask

  task automatic wait_frames(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (rx_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, rx_q.size(), n);
  endtask

  // Receiver: detect start at a negedge sample, sample bits mid-period.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && TXD === 1'b0) begin
        int t0;
        logic [7:0] b;
        logic ab;
        t0 = cyc;
        b  = '0;
        ab = 1'b0;
        for (int k = 1; k <= 95; k++) begin
          @(negedge clk);
          if (reset) ab = 1'b1;
          if (k >= 15 && k < 95 && ((k - 15) % 10) == 0)
            b[(k - 15) / 10] = TXD;
          if (k == 95 && TXD !== 1'b1 && !ab) frame_err++;
        end
        if (!ab) begin
          rx_q.push_back(b);
          rx_t.push_back(t0);
        end
      end
    end
  end

  initial begin
    logic [31:0] rd;
    logic        w [1:103];
    logic [9:0]  v;
    logic        eb;
    logic [7:0]  pat;
    logic        allhi;
    int          n;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_txd", {31'd0, TXD}, 32'd1);
    chk("rst_rdata", io_rdata, 32'd0);
    reset = 1'b0;
    bus_rd(32'h4, rd);
    chk("rst_status", rd, 32'h02);

    // 0x55 frame timing, single strobe bit enough to write
    pat = 8'h55;
    bus_wr(1'b1, 32'h0, 32'hABCD_EF55, 4'b1000);
    for (int k = 1; k <= 103; k++) begin
      @(negedge clk);
      if (k == 1) begin
        io_sel = 1'b0;
        mem_wmask = '0;
      end
      w[k] = TXD;
    end
    chk("f55_pre", {30'd0, w[1], w[2]}, 32'd3);
    for (int p = 0; p < 10; p++) begin
      if (p == 0) eb = 1'b0;
      else if (p == 9) eb = 1'b1;
      else eb = pat[p - 1];
      for (int j = 0; j < 10; j++) v[j] = w[3 + 10 * p + j];
      chk($sformatf("f55_bit%0d", p), {22'd0, v}, eb ? 32'h3FF : 32'h0);
    end
    chk("f55_after", {31'd0, w[103]}, 32'd1);
    bus_rd(32'h4, rd);
    chk("f55_status", rd, 32'h02);
    wait_frames(1, 50, "f55_rx_count");
    chk("f55_rx", {24'd0, rx_q[0]}, 32'h55);

    // Back-to-back bytes
    bus_wr(1'b1, 32'h0, 32'h41, 4'hF);
    bus_wr(1'b1, 32'h0, 32'h42, 4'hF);
    bus_idle();
    wait_frames(3, 400, "b2b_count");
    chk("b2b_byte0", {24'd0, rx_q[1]}, 32'h41);
    chk("b2b_byte1", {24'd0, rx_q[2]}, 32'h42);
    chk("b2b_gap", rx_t[2] - rx_t[1], 32'd101);
    repeat (20) @(negedge clk);

    // Six consecutive writes: one popped, four stored, one dropped
    for (int i = 0; i < 6; i++)
      bus_wr(1'b1, 32'h0, 32'h10 + i, 4'hF);
    bus_idle();
    bus_rd(32'h4, rd);
    chk("ovf_status", rd, 32'h0D);
    bus_rd(32'h4, rd);
    chk("ovf_cleared", rd, 32'h09);
    wait_frames(8, 800, "ovf_count");
    for (int i = 0; i < 5; i++)
      chk($sformatf("ovf_byte%0d", i), {24'd0, rx_q[3 + i]}, 32'h10 + i);
    repeat (20) @(negedge clk);
    bus_rd(32'h4, rd);
    chk("ovf_done_status", rd, 32'h02);
    repeat (30) @(negedge clk);
    chk("ovf_no_extra", rx_q.size(), 32'd8);

    // Reset mid-frame with two bytes queued
    n = rx_q.size();
    bus_wr(1'b1, 32'h0, 32'hF0, 4'hF);
    bus_wr(1'b1, 32'h0, 32'hAA, 4'hF);
    bus_wr(1'b1, 32'h0, 32'hBB, 4'hF);
    bus_idle();
    bus_rd(32'h4, rd);
    chk("pre_rst_status", rd, 32'h08);
    repeat (36) @(negedge clk);
    chk("pre_rst_txd", {31'd0, TXD}, 32'd0);
    reset = 1'b1;
    #1;
    chk("rst_txd_async", {31'd0, TXD}, 32'd1);
    chk("rst_rdata_async", io_rdata, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    bus_rd(32'h4, rd);
    chk("post_rst_status", rd, 32'h02);
    allhi = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (TXD !== 1'b1) allhi = 1'b0;
    end
    chk("post_rst_idle", {31'd0, allhi}, 32'd1);
    chk("post_rst_frames", rx_q.size(), n);

    // Ignored writes: deselected, wrong register, no strobes
    bus_wr(1'b0, 32'h0, 32'h33, 4'hF);
    bus_wr(1'b1, 32'h8, 32'h77, 4'hF);
    bus_wr(1'b1, 32'hC, 32'h78, 4'hF);
    bus_wr(1'b1, 32'h0, 32'h99, 4'h0);
    bus_idle();
    allhi = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (TXD !== 1'b1) allhi = 1'b0;
    end
    chk("ign_idle", {31'd0, allhi}, 32'd1);
    bus_rd(32'h4, rd);
    chk("ign_status", rd, 32'h02);
    bus_rd(32'h8, rd);
    chk("ign_rd_reg2", rd, 32'h0);
    bus_rd(32'h0, rd);
    chk("ign_rd_txdata", rd, 32'h0);
    chk("ign_frames", rx_q.size(), n);
    chk("frame_errors", frame_err, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
